// File: rtl/fp_pkg.sv
// Shared floating-point constants and FSM encoding for the multiplier
// and normalizer datapaths.
package fp_pkg;

   localparam int EW   = 8;
   localparam int FW   = 23;
   localparam int BIAS = 127;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/mant_mult_seq.sv
// Sequential shift-add mantissa multiplier: one multiplier bit per cycle,
// fixed MW-cycle run, with sign/exponent/zero side results for the normalizer.
module mant_mult_seq #(
   parameter int EW = fp_pkg::EW,
   parameter int FW = fp_pkg::FW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [EW+FW:0]       a,
   input  logic [EW+FW:0]       b,
   output logic                 busy,
   output logic                 done,
   output logic [2*(FW+1)-1:0]  prdt,
   output logic                 sign,
   output logic signed [EW+1:0] exp_sum,
   output logic                 zero
);
   import fp_pkg::*;

   localparam int MW = FW + 1;
   localparam int PW = 2 * MW;
   localparam int CW = $clog2(MW) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MW - 1);
   localparam logic [EW+1:0] BIAS_X   = (EW+2)'(BIAS);

   mult_state_t   state;
   logic [PW-1:0] acc;
   logic [MW-1:0] mcand;
   logic [MW-1:0] mplier;
   logic [CW-1:0] cnt;

   logic [EW-1:0] ea, eb;
   logic [FW-1:0] fa, fb;
   logic [PW-1:0] addend;

   assign ea = a[FW +: EW];
   assign eb = b[FW +: EW];
   assign fa = a[FW-1:0];
   assign fb = b[FW-1:0];

   // Partial product for the current multiplier bit, weighted by the step count.
   assign addend = {{MW{1'b0}}, mcand} << cnt;

   // NOTE: every register here uses non-blocking assignment so all state
   // updates see the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are reset too, so an aborted run
         // leaves nothing behind and a fresh start begins from a known state.
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         prdt    <= '0;
         sign    <= 1'b0;
         exp_sum <= '0;
         zero    <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Hidden bit is 0 for a zero (or subnormal) exponent field.
                  mcand   <= {|ea, fa};
                  mplier  <= {|eb, fb};
                  acc     <= '0;
                  cnt     <= '0;
                  sign    <= a[EW+FW] ^ b[EW+FW];
                  exp_sum <= signed'({2'b00, ea} + {2'b00, eb} - BIAS_X);
                  zero    <= (ea == '0) || (eb == '0);
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (mplier[0]) acc <= acc + addend;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_CNT) state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               prdt  <= acc;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mant_mult_seq.sv
// Directed self-checking bench for mant_mult_seq at default widths.
module tb_mant_mult_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done, sign, zero;
   logic [47:0] prdt;
   logic [9:0]  exp_sum;

   int n_assert = 0;
   int n_fail   = 0;

   mant_mult_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .prdt    (prdt),
      .sign    (sign),
      .exp_sum (exp_sum),
      .zero    (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses start for one edge, then expects done exactly 25 edges later.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [47:0] e_prdt, input logic e_sign,
                         input logic [9:0] e_exp, input logic e_zero);
      int lat;
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, " busy_run"}, 64'(busy), 64'd1);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      check({tag, " latency"}, 64'(lat), 64'd25);
      check({tag, " prdt"},    64'(prdt), 64'(e_prdt));
      check({tag, " sign"},    64'(sign), 64'(e_sign));
      check({tag, " exp_sum"}, 64'(exp_sum), 64'(e_exp));
      check({tag, " zero"},    64'(zero), 64'(e_zero));
      check({tag, " busy_done"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1 check({tag, " done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n_done;
      int t_first, t_second, edge_no;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy",    64'(busy), 64'd0);
      check("rst done",    64'(done), 64'd0);
      check("rst prdt",    64'(prdt), 64'd0);
      check("rst sign",    64'(sign), 64'd0);
      check("rst exp_sum", 64'(exp_sum), 64'd0);
      check("rst zero",    64'(zero), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      run_op("one_x_one",  32'h3F800000, 32'h3F800000, 48'h400000000000, 1'b0, 10'd127, 1'b0);
      run_op("p15_x_p15",  32'h3FC00000, 32'h3FC00000, 48'h900000000000, 1'b0, 10'd127, 1'b0);
      run_op("m2_x_p3",    32'hC0000000, 32'h40400000, 48'h600000000000, 1'b1, 10'd129, 1'b0);
      run_op("zero_x_one", 32'h00000000, 32'h3F800000, 48'h000000000000, 1'b0, 10'd0,   1'b1);
      // Exponent underflow: 1+1-127 = -125 in 10-bit two's complement.
      run_op("exp_under",  32'h00800000, 32'h00800000, 48'h400000000000, 1'b0, 10'h383, 1'b0);
      // Exponent overflow: 254+254-127 = 381.
      run_op("exp_over",   32'h7F000000, 32'h7F000000, 48'h400000000000, 1'b0, 10'd381, 1'b0);

      // Second start during RUN, with changed operands, must be ignored.
      @(negedge clk);
      a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n_done = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (i == 5) begin
            a = 32'hC0000000; b = 32'hC0000000; start = 1'b1;
         end
         if (i == 6) start = 1'b0;
         if (done) n_done++;
      end
      check("ignore done_count", 64'(n_done), 64'd1);
      check("ignore prdt",       64'(prdt), 64'h600000000000);
      check("ignore sign",       64'(sign), 64'd0);
      check("ignore exp_sum",    64'(exp_sum), 64'd128);

      // Reset mid-RUN aborts with all outputs cleared immediately.
      @(negedge clk);
      a = 32'h3FC00000; b = 32'h3FC00000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy",    64'(busy), 64'd0);
      check("abort done",    64'(done), 64'd0);
      check("abort prdt",    64'(prdt), 64'd0);
      check("abort sign",    64'(sign), 64'd0);
      check("abort exp_sum", 64'(exp_sum), 64'd0);
      check("abort zero",    64'(zero), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1 if (done) n_done++;
      end
      check("abort no_done", 64'(n_done), 64'd0);
      run_op("after_abort", 32'hC0000000, 32'h40400000, 48'h600000000000, 1'b1, 10'd129, 1'b0);

      // start held high: one result every MW+2 = 26 cycles.
      @(negedge clk);
      a = 32'h3FC00000; b = 32'h40000000; start = 1'b1;
      t_first = -1; t_second = -1; edge_no = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         edge_no++;
         if (done) begin
            if (t_first < 0) t_first = edge_no;
            else begin
               t_second = edge_no;
               start = 1'b0;
               break;
            end
         end
      end
      check("b2b spacing", 64'(t_second - t_first), 64'd26);
      check("b2b prdt",    64'(prdt), 64'h600000000000);
      check("b2b exp_sum", 64'(exp_sum), 64'd128);
      repeat (30) @(posedge clk);
      #1 check("b2b idle", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mant_mult_seq.md
MANT_MULT_SEQ -- requirements
Module: mant_mult_seq

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width.
REQ-002 SHALL have parameter FW, default 23, fraction width; mantissa width MW = FW+1 and product width PW = 2*MW (48 at defaults).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-006 SHALL have port a, input, 1+EW+FW, IEEE-754 operand A (sign, exponent, fraction).
REQ-007 SHALL have port b, input, 1+EW+FW, IEEE-754 operand B.
REQ-008 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-010 SHALL have port prdt, output, PW, unsigned mantissa product, the normalizer's input.
REQ-011 SHALL have port sign, output, 1, result sign.
REQ-012 SHALL have port exp_sum, output, EW+2, signed biased exponent sum ea+eb-BIAS.
REQ-013 SHALL have port zero, output, 1, high when either operand has a zero exponent field.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE with start=1: SHALL capture ma = {|ea, fa} and mb = {|eb, fb}, with the hidden bit 0 for a zero exponent; clear the PW-bit accumulator; load counter 0; latch sign = a[MSB]^b[MSB], exp_sum = ea+eb-BIAS, and zero; go to RUN.
REQ-016 RUN, each cycle: if the multiplier LSB is 1, the accumulator SHALL add the multiplicand shifted left by the counter value; the multiplier SHALL shift right by 1; the counter SHALL increment.
REQ-017 RUN SHALL last exactly MW cycles (24 at defaults), then go to DONE.
REQ-018 DONE SHALL last one cycle, drive done=1, copy the accumulator to prdt, then return to IDLE.
REQ-019 Latency: done SHALL go high in the cycle beginning MW+1 rising edges after the edge that sampled start.
REQ-020 prdt, sign, exp_sum and zero SHALL hold their values from done until the next DONE; sign, exp_sum and zero update at start acceptance.
REQ-021 start while busy SHALL be ignored, not queued.
REQ-022 start held high continuously SHALL begin a new operation in the IDLE cycle after each DONE, giving back-to-back throughput of one result per MW+2 cycles.
REQ-023 A zero operand SHALL still run the full MW cycles, producing prdt=0; latency is fixed and data-independent.
REQ-024 a and b SHALL be sampled only at start acceptance; changes during RUN have no effect.
REQ-025 The accumulator SHALL never overflow PW bits, since the maximum product is less than 2^PW.
REQ-026 exp_sum SHALL be computed in EW+2 bits, signed, so underflow below 0 and overflow above 2^EW-1 are representable.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE; busy=0, done=0, prdt=0, sign=0, exp_sum=0, zero=0; accumulator, multiplier and counter cleared.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block accepts start normally.
REQ-029 The first start SHALL be sampled no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-030 EW, FW, BIAS (127) and the FSM state encodings SHALL live in the shared package fp_pkg, also used by the normalizer.
REQ-031 The block SHALL be a single module with no sub-module; the datapath is a shift-add accumulator, a right-shifting multiplier register and a log2(MW)+1-bit counter.

Verification
REQ-032 a=32'h3F800000, b=32'h3F800000, start pulse -> done on the 25th edge after the sampling edge; prdt=48'h400000000000, sign=0, exp_sum=127, zero=0.
REQ-033 a=32'h3FC00000, b=32'h3FC00000 (1.5*1.5) -> prdt=48'h900000000000, sign=0, exp_sum=127.
REQ-034 a=32'hC0000000, b=32'h40400000 (-2*3) -> prdt=48'h600000000000, sign=1, exp_sum=129.
REQ-035 a=32'h00000000, b=32'h3F800000 -> prdt=0, zero=1, exp_sum=0, same 25-cycle latency.
REQ-036 Second start pulsed during RUN -> ignored; only one done pulse; results from the first operands.
REQ-037 rst_n pulsed low at RUN cycle 10 -> all outputs immediately 0, no done; a fresh start then yields the correct result.
